// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the HDMI PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN,
      ST_FAIL
   } pll_state_t;

   localparam int unsigned DEF_RST_CYCLES          = 16;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 500000;
   localparam int unsigned DEF_MAX_RETRY           = 7;
   localparam int unsigned DEF_SYNC_STAGES         = 2;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset to 0.
module sync_bit #(
   parameter int unsigned N = 2
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [N-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
      end
   end

   assign o_q = r_sync[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Power-up / relock sequencer for the HDMI clocking PLL: reset pulse, lock wait
// with bounded retries, lock qualification, then release of the video reset.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned MAX_RETRY           = DEF_MAX_RETRY,
   parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       video_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_cnt
);

   localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

   pll_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_retry;
   logic [7:0]       r_lost;
   logic             r_pll_reset;
   logic             r_video_rst_n;
   logic             r_ready;
   logic             r_fail;

   pll_state_t       w_next;
   logic [3:0]       w_retry_next;
   logic [3:0]       w_retry_inc;
   logic [7:0]       w_lost_next;
   logic             w_restart;
   logic             w_lock_s;

   sync_bit #(
      .N (SYNC_STAGES)
   ) u_lock_sync (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_d     (pll_lock),
      .o_q     (w_lock_s)
   );

   assign w_retry_inc = r_retry + 4'd1;

   // relock_req outranks the timeout, which outranks any lock event.
   always_comb begin
      w_next       = r_state;
      w_retry_next = r_retry;
      w_lost_next  = r_lost;
      if (relock_req) begin
         w_next       = ST_RESET;
         w_retry_next = '0;
      end else begin
         case (r_state)
            ST_RESET: begin
               if (r_cnt == RST_LAST) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (r_cnt == TIMEOUT_LAST) begin
                  w_retry_next = w_retry_inc;
                  w_next       = (w_retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
               end else if (w_lock_s) begin
                  w_next = ST_STABLE;
               end
            end
            ST_STABLE: begin
               if (!w_lock_s) begin
                  w_next = ST_WAIT_LOCK;
               end else if (r_cnt == STABLE_LAST) begin
                  w_next       = ST_RUN;
                  w_retry_next = '0;
               end
            end
            ST_RUN: begin
               if (!w_lock_s) begin
                  if (r_lost != '1) w_lost_next = r_lost + 8'd1;
                  w_next = ST_RESET;
               end
            end
            ST_FAIL: begin
               w_next = ST_FAIL;
            end
            default: begin
               w_next = ST_RESET;
            end
         endcase
      end
   end

   // A relock request restarts the counter even when already in RESET.
   assign w_restart = relock_req || (w_next != r_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RESET;
         r_cnt         <= '0;
         r_retry       <= '0;
         r_lost        <= '0;
         r_pll_reset   <= 1'b1;
         r_video_rst_n <= 1'b0;
         r_ready       <= 1'b0;
         r_fail        <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_restart || (w_next == ST_RUN) || (w_next == ST_FAIL)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_retry       <= w_retry_next;
         r_lost        <= w_lost_next;
         r_pll_reset   <= (w_next == ST_RESET) || (w_next == ST_FAIL);
         r_video_rst_n <= (w_next == ST_RUN);
         r_ready       <= (w_next == ST_RUN);
         r_fail        <= (w_next == ST_FAIL);
      end
   end

   assign pll_reset   = r_pll_reset;
   assign video_rst_n = r_video_rst_n;
   assign ready       = r_ready;
   assign fail        = r_fail;
   assign retry_cnt   = r_retry;
   assign lost_cnt    = r_lost;

endmodule
